// File: rtl/biset_master_pkg.sv
// -----------------------------------------------------------------------------
// biset_master_pkg
//   Shared BiSet bus definitions: field widths, request/reply layouts and
//   small helpers used to build requests and decode replies.
//   Request layout (MSB..LSB): valid, wr, addr, data.
//   Reply layout   (MSB..LSB): valid, data.
// -----------------------------------------------------------------------------
package biset_master_pkg;

  localparam int unsigned BISET_ADDRLEN  = 16;
  localparam int unsigned BISET_DATALEN  = 16;
  localparam int unsigned BISET_REQLEN   = 2 + BISET_ADDRLEN + BISET_DATALEN;
  localparam int unsigned BISET_REPLYLEN = 1 + BISET_DATALEN;

  typedef struct packed {
    logic                     valid;
    logic                     wr;
    logic [BISET_ADDRLEN-1:0] addr;
    logic [BISET_DATALEN-1:0] data;
  } biSetRequest;

  typedef struct packed {
    logic                     valid;
    logic [BISET_DATALEN-1:0] data;
  } biSetReply;

  function automatic logic BiSetReplyValid(input logic [BISET_REPLYLEN-1:0] reply);
    biSetReply r;
    r = biSetReply'(reply);
    return r.valid;
  endfunction

  function automatic logic [BISET_DATALEN-1:0] BiSetReplyData(input logic [BISET_REPLYLEN-1:0] reply);
    biSetReply r;
    r = biSetReply'(reply);
    return r.data;
  endfunction

  function automatic biSetRequest BiSetMakeRequest(input logic                     wr,
                                                   input logic [BISET_ADDRLEN-1:0] addr,
                                                   input logic [BISET_DATALEN-1:0] data);
    biSetRequest r;
    r.valid = 1'b1;
    r.wr    = wr;
    r.addr  = addr;
    r.data  = data;
    return r;
  endfunction

endpackage

// File: rtl/biset_master_timeout_counter.sv
// -----------------------------------------------------------------------------
// biset_timeout_counter
//   Reply-wait counter for the BiSet master. Cleared while the request is on
//   the bus, counts each waiting cycle, flags the last permitted wait cycle.
//   Ports:
//     clk_i, reset_i : clock, asynchronous active-high reset
//     clear_i        : return count to zero (priority over enable_i)
//     enable_i       : advance count by one
//     expired_o      : count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module biset_timeout_counter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned     CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/biset_master.sv
// -----------------------------------------------------------------------------
// biset_master
//   Initiator end of the BiSet bus. Takes one local register command at a
//   time, drives it as a single-cycle request, waits for the merged reply
//   and returns read data or a timeout error to the local side.
//   Ports:
//     clk_i, reset_i           : clock, asynchronous active-high reset
//     cmd_valid_i/cmd_ready_o  : local command handshake
//     cmd_wr_i, cmd_addr_i,
//     cmd_data_i               : command fields (1 = write)
//     rsp_valid_o              : one-cycle response strobe
//     rsp_data_o, rsp_err_o    : read data (0 for writes), timeout flag
//     req_o                    : BiSet request to all slaves
//     reply_i                  : merged BiSet reply
//   Optional: define BISET_MASTER_RETRY_EN to reissue a timed-out request up
//   to RETRIES times before reporting the error.
// -----------------------------------------------------------------------------
module biset_master
  import biset_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned RETRIES = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_wr_i,
  input  logic [BISET_ADDRLEN-1:0]  cmd_addr_i,
  input  logic [BISET_DATALEN-1:0]  cmd_data_i,
  output logic                      rsp_valid_o,
  output logic [BISET_DATALEN-1:0]  rsp_data_o,
  output logic                      rsp_err_o,
  output logic [BISET_REQLEN-1:0]   req_o,
  input  logic [BISET_REPLYLEN-1:0] reply_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e                   state_q, state_d;
  logic                     wr_q, wr_d;
  logic [BISET_ADDRLEN-1:0] addr_q, addr_d;
  logic [BISET_DATALEN-1:0] data_q, data_d;
  logic [BISET_DATALEN-1:0] rsp_data_q, rsp_data_d;
  logic                     rsp_err_q, rsp_err_d;

  logic reply_valid;
  logic cnt_clear, cnt_enable, cnt_expired;
  logic retry_pending;

  assign reply_valid = BiSetReplyValid(reply_i);

  biset_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clear_i   (cnt_clear),
    .enable_i  (cnt_enable),
    .expired_o (cnt_expired)
  );

`ifdef BISET_MASTER_RETRY_EN
  logic [15:0] retry_q, retry_d;

  assign retry_pending = (retry_q < 16'(RETRIES));

  // Count restarts only for a fresh command; reissues from WAIT keep it.
  always_comb begin
    retry_d = retry_q;
    if (state_q == IDLE && cmd_valid_i) begin
      retry_d = '0;
    end else if (state_q == WAIT && !reply_valid && cnt_expired && retry_pending) begin
      retry_d = retry_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`else
  logic [31:0] unused_retries;
  assign unused_retries = RETRIES;
  assign retry_pending  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          wr_d    = cmd_wr_i;
          addr_d  = cmd_addr_i;
          data_d  = cmd_data_i;
          state_d = REQ;
        end
      end
      REQ: begin
        cnt_clear = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        // A reply in the expiry cycle still wins over the timeout.
        if (reply_valid) begin
          rsp_data_d = wr_q ? '0 : BiSetReplyData(reply_i);
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_expired) begin
          if (retry_pending) begin
            state_d = REQ;
          end else begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end
        end else begin
          cnt_enable = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    req_o = '0;
    if (state_q == REQ) begin
      req_o = BiSetMakeRequest(wr_q, addr_q, data_q);
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
